// File: rtl/dda_move_engine.sv
// rtl/dda_move_engine.sv - buffered multi-axis DDA segment executor with step rollback
// Define DDA_ACCEL_EN to store and apply the per-axis increment delta (acceleration).
module dda_move_engine #(
   parameter int AXES     = 3,
   parameter int BUF_BITS = 2,
   parameter int W        = 64,
   parameter int DIV_BITS = 8
) (
   input  logic                  CLK,
   input  logic                  resetn,
   input  logic [DIV_BITS-1:0]   clock_divisor,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [W-1:0]          load_duration,
   input  logic [AXES-1:0]       load_dir,
   input  logic [AXES*W-1:0]     load_increment,
   input  logic [AXES*W-1:0]     load_incincr,
   input  logic                  abort,
   output logic [AXES-1:0]       step,
   output logic [AXES-1:0]       dir,
   output logic                  busy,
   output logic                  move_done,
   output logic [BUF_BITS:0]     buf_level
);
   localparam int DEPTH = 1 << BUF_BITS;
   localparam logic signed [W-1:0] STEP_K = {1'b0, {(W-1){1'b1}}} - W'(100);
   localparam logic signed [W-1:0] ZERO   = '0;

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

   logic [W-1:0]          dur_mem [DEPTH];
   logic [AXES-1:0]       dir_mem [DEPTH];
   logic [AXES*W-1:0]     inc_mem [DEPTH];
`ifdef DDA_ACCEL_EN
   logic [AXES*W-1:0]     ii_mem  [DEPTH];
   logic signed [W-1:0]   ii_r    [AXES];
`else
   logic                  unused_incincr;
   assign unused_incincr = ^load_incincr;
`endif

   logic [BUF_BITS-1:0]   wr_ptr, rd_ptr;
   logic [BUF_BITS:0]     level;
   logic [W-1:0]          tickdown;
   logic [DIV_BITS-1:0]   clkaccum;
   logic signed [W-1:0]   acc     [AXES];
   logic signed [W-1:0]   acc_nxt [AXES];
   logic signed [W-1:0]   inc_r   [AXES];
   logic signed [W-1:0]   inc_nxt [AXES];
   state_t                state, state_nxt;
   logic                  fifo_empty, push, pop, tick, seg_end;

   assign fifo_empty = (level == '0);
   assign load_ready = (level != (BUF_BITS+1)'(DEPTH));
   assign buf_level  = level;
   assign push       = load_valid && load_ready && !abort;
   assign seg_end    = tick && (tickdown == '0);

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (!fifo_empty) state_nxt = LOAD;
         LOAD:    state_nxt = RUN;
         RUN:     if (seg_end) state_nxt = fifo_empty ? IDLE : LOAD;
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   always_comb begin
      busy = (state != IDLE);
      pop  = (state == LOAD);
      tick = (state == RUN) && (clkaccum == '0);
   end

   // Segment storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge CLK) begin
      if (push) begin
         dur_mem[wr_ptr] <= load_duration;
         dir_mem[wr_ptr] <= load_dir;
         inc_mem[wr_ptr] <= load_increment;
`ifdef DDA_ACCEL_EN
         ii_mem[wr_ptr]  <= load_incincr;
`endif
      end
   end

   // Tick add and rollback subtract fold into one update so neither is lost.
   always_comb begin
      for (int i = 0; i < AXES; i++) begin
         acc_nxt[i] = acc[i];
         if (tick) acc_nxt[i] = acc_nxt[i] + inc_r[i];
         if (acc[i] > ZERO) acc_nxt[i] = acc_nxt[i] - STEP_K;
         inc_nxt[i] = inc_r[i];
         if (state == LOAD) inc_nxt[i] = inc_mem[rd_ptr][i*W +: W];
`ifdef DDA_ACCEL_EN
         else if (tick) inc_nxt[i] = inc_r[i] + ii_r[i];
`endif
      end
   end

   always_comb begin
      step = '0;
      for (int i = 0; i < AXES; i++) step[i] = (acc[i] > ZERO);
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         tickdown  <= '0;
         clkaccum  <= '0;
         dir       <= '0;
         move_done <= 1'b0;
         for (int i = 0; i < AXES; i++) begin
            acc[i]   <= '0;
            inc_r[i] <= '0;
`ifdef DDA_ACCEL_EN
            ii_r[i]  <= '0;
`endif
         end
      end else if (abort) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         tickdown  <= '0;
         clkaccum  <= '0;
         move_done <= 1'b0;
         for (int i = 0; i < AXES; i++) begin
            acc[i]   <= '0;
            inc_r[i] <= '0;
`ifdef DDA_ACCEL_EN
            ii_r[i]  <= '0;
`endif
         end
      end else begin
         move_done <= seg_end;
         if (push) wr_ptr <= wr_ptr + BUF_BITS'(1);
         if (pop)  rd_ptr <= rd_ptr + BUF_BITS'(1);
         if (push && !pop)      level <= level + (BUF_BITS+1)'(1);
         else if (pop && !push) level <= level - (BUF_BITS+1)'(1);

         if (state == LOAD) begin
            tickdown <= dur_mem[rd_ptr];
            dir      <= dir_mem[rd_ptr];
            clkaccum <= clock_divisor;
         end else if (state == RUN) begin
            if (tick) begin
               clkaccum <= clock_divisor;
               tickdown <= tickdown - W'(1);
            end else begin
               clkaccum <= clkaccum - DIV_BITS'(1);
            end
         end

         for (int i = 0; i < AXES; i++) begin
            acc[i]   <= acc_nxt[i];
            inc_r[i] <= inc_nxt[i];
`ifdef DDA_ACCEL_EN
            if (state == LOAD) ii_r[i] <= ii_mem[rd_ptr][i*W +: W];
`endif
         end
      end
   end
endmodule

// File: tb/tb_dda_move_engine.sv
// tb/tb_dda_move_engine.sv - directed checks for dda_move_engine (either DDA_ACCEL_EN build)
module tb_dda_move_engine;
   logic          CLK;
   logic          resetn;
   logic [7:0]    clock_divisor;
   logic          load_valid;
   logic          load_ready;
   logic [63:0]   load_duration;
   logic [2:0]    load_dir;
   logic [191:0]  load_increment;
   logic [191:0]  load_incincr;
   logic          abort;
   logic [2:0]    step;
   logic [2:0]    dir;
   logic          busy;
   logic          move_done;
   logic [2:0]    buf_level;

   int total = 0;
   int bad   = 0;

   dda_move_engine dut (
      .CLK(CLK), .resetn(resetn), .clock_divisor(clock_divisor),
      .load_valid(load_valid), .load_ready(load_ready), .load_duration(load_duration),
      .load_dir(load_dir), .load_increment(load_increment), .load_incincr(load_incincr),
      .abort(abort), .step(step), .dir(dir), .busy(busy), .move_done(move_done),
      .buf_level(buf_level)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [63:0] dur, input logic [2:0] d,
                        input logic [63:0] inc0, input logic [63:0] ii0);
      load_valid     = 1'b1;
      load_duration  = dur;
      load_dir       = d;
      load_increment = {128'h0, inc0};
      load_incincr   = {128'h0, ii0};
      @(negedge CLK);
   endtask

   initial begin
      int rises, highs, md_cnt, md_at, cyc;
      int md_t [6];
      logic prev, found;

      resetn = 1'b0; clock_divisor = 8'd0; load_valid = 1'b0; load_duration = '0;
      load_dir = '0; load_increment = '0; load_incincr = '0; abort = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rst_step", step, 0);
      chk("rst_dir", dir, 0);
      chk("rst_busy", busy, 0);
      chk("rst_move_done", move_done, 0);
      chk("rst_buf_level", buf_level, 0);
      chk("rst_load_ready", load_ready, 1);
      resetn = 1'b1;
      @(negedge CLK);

      // Constant velocity: inc = 2^62, ticks every RUN cycle, ten ticks.
      offer(64'd9, 3'b101, 64'h4000_0000_0000_0000, 64'h0);
      load_valid = 1'b0;
      chk("cv_level_k0", buf_level, 1);
      chk("cv_busy_k0", busy, 0);
      rises = 0; md_cnt = 0; md_at = -1; prev = step[0];
      for (int k = 1; k <= 14; k++) begin
         @(negedge CLK);
         if (step[0] && !prev) rises++;
         prev = step[0];
         if (move_done) begin md_cnt++; md_at = k; end
         if (k == 1) chk("cv_busy_load", busy, 1);
         if (k == 2) chk("cv_dir", dir, 3'b101);
         if (k == 2) chk("cv_level_pop", buf_level, 0);
         if (k == 3) chk("cv_acc_tick1", dut.acc[0], 64'h4000_0000_0000_0000);
         if (k == 4) chk("cv_acc_coincident", dut.acc[0], 64'd101);
         if (k == 5) chk("cv_acc_tick3", dut.acc[0], 64'hC000_0000_0000_00CA);
      end
      chk("cv_step_pulses", rises, 5);
      chk("cv_done_count", md_cnt, 1);
      chk("cv_done_edge", md_at, 12);
      chk("cv_idle", busy, 0);
      chk("cv_inc_const", dut.inc_r[0], 64'h4000_0000_0000_0000);

      // Back-to-back: long preload, then four short segments fill the FIFO.
      clock_divisor = 8'd2;
      offer(64'd50, 3'b010, 64'h0, 64'h0);
      for (int s = 0; s < 4; s++) offer(64'd3, 3'b110, 64'h0, 64'h0);
      chk("b2b_level_full", buf_level, 4);
      load_duration = 64'd3; load_dir = 3'b111;
      chk("b2b_ready_low", load_ready, 0);
      @(negedge CLK);
      load_valid = 1'b0;
      chk("b2b_no_overwrite", buf_level, 4);
      chk("b2b_dir_preload", dir, 3'b010);
      md_cnt = 0;
      for (cyc = 0; cyc < 300; cyc++) begin
         @(negedge CLK);
         if (move_done) begin
            if (md_cnt < 6) md_t[md_cnt] = cyc;
            md_cnt++;
         end
      end
      chk("b2b_done_count", md_cnt, 5);
      for (int g = 1; g < 5; g++) chk($sformatf("b2b_gap%0d", g), md_t[g] - md_t[g-1], 13);
      chk("b2b_dir_last", dir, 3'b110);
      chk("b2b_idle", busy, 0);

      // Abort with three segments queued and a same-cycle push.
      clock_divisor = 8'd3;
      offer(64'd100, 3'b001, 64'h4000_0000_0000_0000, 64'h0);
      for (int s = 0; s < 3; s++) offer(64'd5, 3'b001, 64'h1, 64'h0);
      load_valid = 1'b0;
      repeat (5) @(negedge CLK);
      chk("ab_level_pre", buf_level, 3);
      chk("ab_busy_pre", busy, 1);
      abort = 1'b1;
      load_valid = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      load_valid = 1'b0;
      chk("ab_level", buf_level, 0);
      chk("ab_busy", busy, 0);
      chk("ab_step", step, 0);
      chk("ab_move_done", move_done, 0);
      chk("ab_acc", dut.acc[0], 64'h0);
      chk("ab_inc", dut.inc_r[0], 64'h0);
      md_cnt = 0;
      repeat (10) begin
         @(negedge CLK);
         if (move_done || busy) md_cnt++;
      end
      chk("ab_stays_idle", md_cnt, 0);
      chk("ab_push_dropped", buf_level, 0);

      // Eight-tick segment, acc starts at zero after the abort.
      clock_divisor = 8'd0;
`ifdef DDA_ACCEL_EN
      offer(64'd7, 3'b001, 64'h0, 64'h1000_0000_0000_0000);
`else
      offer(64'd7, 3'b001, 64'h1000_0000_0000_0000, 64'h1000_0000_0000_0000);
`endif
      load_valid = 1'b0;
      rises = 0; highs = 0; md_at = -1; prev = step[0];
      for (int k = 1; k <= 16; k++) begin
         @(negedge CLK);
         if (step[0] && !prev) rises++;
         if (step[0]) highs++;
         prev = step[0];
         if (move_done) md_at = k;
      end
      chk("acc_done_edge", md_at, 10);
`ifdef DDA_ACCEL_EN
      chk("accel_inc_wrapped", dut.inc_r[0], 64'h8000_0000_0000_0000);
      chk("accel_step_rises", rises, 3);
      chk("accel_step_highs", highs, 4);
`else
      chk("cvel_inc_const", dut.inc_r[0], 64'h1000_0000_0000_0000);
      chk("cvel_step_rises", rises, 2);
      chk("cvel_step_highs", highs, 2);
`endif

      // Asynchronous reset mid-RUN while step is high.
      offer(64'd200, 3'b011, 64'h4000_0000_0000_0000, 64'h0);
      load_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge CLK);
         if (step[0]) found = 1'b1;
      end
      chk("ar_step_seen", found, 1);
      #1 resetn = 1'b0;
      #1;
      chk("ar_step", step, 0);
      chk("ar_busy", busy, 0);
      chk("ar_ready", load_ready, 1);
      chk("ar_level", buf_level, 0);
      repeat (2) @(negedge CLK);
      resetn = 1'b1;
      repeat (4) @(negedge CLK);
      chk("ar_post_busy", busy, 0);
      chk("ar_post_step", step, 0);
      chk("ar_post_done", move_done, 0);
      chk("ar_post_dir", dir, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dda_move_engine.md
# dda_move_engine

Multi-axis, buffered DDA move executor for the RAPcores motion path. It accepts fully-formed move segments (duration, per-axis direction, increment, and optional increment-of-increment) from the SPI command decoder through a valid/ready port. Segments are queued in a parametrised FIFO and executed back-to-back on a divided tick. It emits per-axis `step`/`dir` to the H-bridge/microstepper drivers and replaces the single-axis, toggle-latched move logic in `top`.

## Interface
- `AXES`, default 3: number of coordinated axes.
- `BUF_BITS`, default 2: FIFO depth is 2^`BUF_BITS` segments.
- `W`, default 64: width of duration, increment and accumulator (signed).
- `DIV_BITS`, default 8: width of the clock divisor.

- `CLK`  in  1: system clock.
- `resetn`  in  1: asynchronous, active-low reset.
- `clock_divisor`  in  `DIV_BITS`: the tick period is `clock_divisor`+1 cycles.
- `load_valid`  in  1: segment offered.
- `load_ready`  out  1: FIFO not full.
- `load_duration`  in  `W`: tick count minus one.
- `load_dir`  in  `AXES`: direction bits.
- `load_increment`  in  `AXES*W`: signed per-axis increment; axis i occupies bits [i*W +: W].
- `load_incincr`  in  `AXES*W`: signed per-axis increment delta (acceleration).
- `abort`  in  1: synchronous flush/stop.
- `step`  out  `AXES`: high while the axis accumulator is greater than 0.
- `dir`  out  `AXES`: direction of the executing segment.
- `busy`  out  1: the state machine is not IDLE.
- `move_done`  out  1: one-cycle pulse at the end of each segment.
- `buf_level`  out  `BUF_BITS+1`: FIFO occupancy.

## Operation
- **FIFO**
  - A push occurs when `load_valid` and `load_ready` are both high.
  - `load_ready` is low when `buf_level` equals 2^`BUF_BITS`; offers made while full are ignored (no overwrite).
  - Read and write pointers wrap modulo the depth.
- **State machine: IDLE → LOAD → RUN**
  - **IDLE:** if the FIFO is non-empty, go to LOAD.
  - **LOAD** (1 cycle):
    - Pop the head entry.
    - Copy duration to `tickdown`, increment to `inc_r[i]`, and incincr to `ii_r[i]`.
    - Latch `dir`.
    - Set `clkaccum` to `clock_divisor`.
    - Go to RUN.
  - **RUN:** `clkaccum` decrements every cycle. When it is 0, a tick occurs and `clkaccum` reloads from the live `clock_divisor`. On each tick:
    - `acc[i]` += `inc_r[i]`.
    - `inc_r[i]` += `ii_r[i]`.
    - `tickdown` decrements.
    - If `tickdown` was 0 before the decrement, the segment is complete:
      - pulse `move_done`;
      - go to LOAD if the FIFO is non-empty (without passing through IDLE), otherwise go to IDLE.
- **Step rollback**
  - In any cycle where `acc[i]` > 0, subtract `STEP_K` = 2^(W-1)−101 (0x7fffffffffffff9b at W=64).
  - If a tick coincides with a rollback, both apply in the same cycle: `acc` + `inc_r` − `STEP_K`. Neither update is lost.
- **Accumulators**
  - `acc[i]` persists across segments so substep phase stays continuous.
  - `acc[i]` is cleared only by reset or `abort`.
- **Arithmetic**
  - All accumulator arithmetic is W-bit two's-complement and wraps silently.
  - The comparison `acc` > 0 is signed.
- **Abort**
  - Takes effect on the next edge.
  - Empties the FIFO (`buf_level`=0), clears `acc`, `inc_r` and `tickdown`, and forces IDLE.
  - `move_done` is not pulsed.
  - A push presented in the same cycle as `abort` is dropped.

## Timing
- **Reset values:** `step`=0, `dir`=0, `busy`=0, `move_done`=0, `buf_level`=0, `load_ready`=1. All accumulators, pointers and state are cleared, and the state is IDLE.
- **Start-up latency:** a push into an empty FIFO while IDLE at edge n is followed by LOAD at n+1, RUN at n+2, and the first tick at edge n+2+`clock_divisor`.
- **Segment length:** `load_duration`+1 ticks.
- **Tick spacing:** `clock_divisor`+1 cycles; a divisor of 0 ticks every RUN cycle.
- **Back-to-back segments:** exactly one LOAD cycle (no tick) between the final tick of one segment and RUN of the next.
- **Output registration:** `step` is decoded from the registered `acc` with no combinational path from inputs. `dir` changes only on the LOAD edge.
- **Occupancy update:** `buf_level` updates on the edge after a push or pop. A push and a pop in the same cycle leave it unchanged.

## Configuration
- **`DDA_ACCEL_EN` defined:** `load_incincr` is stored in the FIFO and applied on each tick as described above.
- **`DDA_ACCEL_EN` undefined:**
  - `load_incincr` is ignored and no FIFO storage or adders are built for it.
  - `inc_r` stays constant for the whole segment (constant velocity).
  - The port remains present so the interface is identical in both builds.

## Test plan
- **Reset:** hold `resetn`=0 mid-RUN with `acc`>0 → `step`=0, `busy`=0 and `load_ready`=1 immediately (asynchronous); outputs remain idle after release.
- **Single axis, constant velocity:** `clock_divisor`=0, duration=9, inc=0x4000000000000000 → 10 ticks, `step` asserted on every second tick (5 pulses), `move_done` at edge n+12.
- **Back-to-back segments:** push 4 segments (depth 4) with duration=3 and `clock_divisor`=2 → 5th offer sees `load_ready`=0; segments run with one LOAD gap; 4 `move_done` pulses spaced 13 cycles apart.
- **Acceleration (`DDA_ACCEL_EN`):** inc=0, incincr=0x1000000000000000, duration=7 → `inc_r` after 8 ticks equals 0x8000000000000000 (wrapped); step count matches the golden model.
- **Abort:** assert `abort` during RUN with 3 segments queued and a push in the same cycle → next cycle `buf_level`=0, `busy`=0, `step`=0, no `move_done`.
- **Coincident rollback and tick:** set `acc`>0 on the tick edge → `acc` equals old + `inc_r` − `STEP_K` with no lost update.
